// File: rtl/rs_issue_unit_pkg.sv
// Helpers local to the issue-select stage.
//   popcount : number of set bits in a (zero-extended) bitmap
package rs_issue_unit_pkg;

  localparam int unsigned POPCNT_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX_W; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
//   rs_d       : reservation-station entry (readiness flags + payload)
//   ex_issue_t : issue-port bundle (valid, station index, entry copy)
package rv32i_types;

  localparam int unsigned RS_SIZE  = 8;
  localparam int unsigned RS_IDX_W = $clog2(RS_SIZE);

  // Reservation-station entry; r1/r2 mark resolved source operands.
  typedef struct packed {
    logic        valid;
    logic        r1;
    logic        r2;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  rob_tag;
  } rs_d;

  // Issue-port bundle held by the issue unit.
  typedef struct packed {
    logic                valid;
    logic [RS_IDX_W-1:0] idx;
    rs_d                 entry;
  } ex_issue_t;

endpackage

// File: rtl/rs_issue_unit_if.sv
// Issue-stage bus: station contents in, execute issue port out,
// completion in, per-entry free pulses and in-flight count out.
//   master : the issue unit
//   slave  : station / execute side
interface rs_issue_unit_if #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned IDX_W = $clog2(SIZE)
);
  import rv32i_types::*;

  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  rs_d              rs_data [SIZE];
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  rs_d              ex_entry;
  logic [IDX_W-1:0] ex_idx;
  logic             cmpl_valid;
  logic [IDX_W-1:0] cmpl_idx;
  logic [SIZE-1:0]  free;
  logic [CNT_W-1:0] inflight_cnt;

  modport master (
    input  rs_data, flush, ex_ready, cmpl_valid, cmpl_idx,
    output ex_valid, ex_entry, ex_idx, free, inflight_cnt
  );

  modport slave (
    output rs_data, flush, ex_ready, cmpl_valid, cmpl_idx,
    input  ex_valid, ex_entry, ex_idx, free, inflight_cnt
  );

endinterface

// File: rtl/rs_issue_unit_rr_picker.sv
// Combinational picker over the eligibility vector.
// Macro RS_ISSUE_RR_EN: first eligible index at or above i_prio, wrapping;
// otherwise a plain lowest-index priority encoder (no i_prio port).
//   i_elig    : per-entry eligibility
//   i_prio    : round-robin start index (RS_ISSUE_RR_EN only)
//   o_found_c : any entry eligible
//   o_sel_c   : chosen index
module rs_issue_unit_rr_picker #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  i_elig,
`ifdef RS_ISSUE_RR_EN
  input  logic [IDX_W-1:0] i_prio,
`endif
  output logic             o_found_c,
  output logic [IDX_W-1:0] o_sel_c
);

  always_comb begin
    o_found_c = |i_elig;
    o_sel_c   = '0;
`ifdef RS_ISSUE_RR_EN
    // Walk offsets high to low so the smallest offset from i_prio wins;
    // SIZE is a power of two, so the IDX_W-bit add wraps naturally.
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (i_elig[IDX_W'(i_prio + IDX_W'(k))]) o_sel_c = IDX_W'(i_prio + IDX_W'(k));
    end
`else
    for (int j = SIZE - 1; j >= 0; j--) begin
      if (i_elig[j]) o_sel_c = IDX_W'(j);
    end
`endif
  end

endmodule

// File: rtl/rs_issue_unit.sv
// Issue-select stage behind the ALU reservation station. Picks a ready,
// not-yet-issued entry, holds it on a registered valid/ready port, tracks
// issued entries until completion and pulses per-entry frees.
// Macro RS_ISSUE_RR_EN enables round-robin selection (prio register).
//   clk, rst : clock, synchronous active-high reset
//   bus      : rs_issue_unit_if.master (rs_data, flush, ex_*, cmpl_*,
//              free (combinational), inflight_cnt)
// SIZE must not exceed rv32i_types::RS_SIZE (width of ex_issue_t.idx).
module rs_issue_unit
  import rv32i_types::*;
  import rs_issue_unit_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  rs_issue_unit_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  ex_issue_t        r_out;
  logic [SIZE-1:0]  r_issued;
  logic [CNT_W-1:0] r_cnt;

  logic [SIZE-1:0]  w_cmpl_hot;
  logic [SIZE-1:0]  w_elig;
  logic [SIZE-1:0]  w_issued_nxt;
  logic             w_load;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;

`ifdef RS_ISSUE_RR_EN
  logic [IDX_W-1:0] r_prio;
`endif

  // One-hot decode of the completing index.
  always_comb begin
    w_cmpl_hot = '0;
    if (bus.cmpl_valid) w_cmpl_hot[bus.cmpl_idx] = 1'b1;
  end

  assign bus.free = bus.flush ? '0 : w_cmpl_hot;

  // A completing entry is excluded so it cannot re-issue while its slot is freed.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_elig[i] = bus.rs_data[i].valid & bus.rs_data[i].r1 & bus.rs_data[i].r2
                & ~r_issued[i] & ~w_cmpl_hot[i];
    end
  end

  assign w_load = !r_out.valid || bus.ex_ready;

  rs_issue_unit_rr_picker #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_elig    (w_elig),
`ifdef RS_ISSUE_RR_EN
    .i_prio    (r_prio),
`endif
    .o_found_c (w_found),
    .o_sel_c   (w_sel)
  );

  // Completion clears, new issue sets, flush wipes everything.
  always_comb begin
    w_issued_nxt = r_issued & ~w_cmpl_hot;
    if (w_load && w_found) w_issued_nxt[w_sel] = 1'b1;
    if (bus.flush) w_issued_nxt = '0;
  end

  // Issue register, issued bitmap and in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_issued <= '0;
      r_cnt    <= '0;
    end else begin
      r_issued <= w_issued_nxt;
      r_cnt    <= CNT_W'(popcount(POPCNT_MAX_W'(w_issued_nxt)));
      if (bus.flush) begin
        r_out.valid <= 1'b0;
      end else if (w_load) begin
        if (w_found) begin
          r_out.valid <= 1'b1;
          r_out.idx   <= RS_IDX_W'(w_sel);
          r_out.entry <= bus.rs_data[w_sel];
        end else begin
          r_out.valid <= 1'b0;
        end
      end
    end
  end

`ifdef RS_ISSUE_RR_EN
  // Round-robin pointer; untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= '0;
    end else if (!bus.flush && w_load && w_found) begin
      r_prio <= IDX_W'(w_sel + IDX_W'(1));
    end
  end
`endif

  assign bus.ex_valid     = r_out.valid;
  assign bus.ex_idx       = IDX_W'(r_out.idx);
  assign bus.ex_entry     = r_out.entry;
  assign bus.inflight_cnt = r_cnt;

endmodule

// File: tb/tb_rs_issue_unit.sv
// Bench for rs_issue_unit: per-cycle vector table plus hand sequences for
// round-robin order, all-issued and reset mid-operation. Issued entries are
// predicted into a scoreboard queue and checked on each transfer.
module tb_rs_issue_unit;
  import rv32i_types::*;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NVEC  = 29;

  logic clk;
  logic rst;

  rs_issue_unit_if #(.SIZE(SIZE)) bus ();

  rs_issue_unit #(.SIZE(SIZE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       v;     // station valid (r1 follows valid)
    logic [7:0]       r2;    // r2 mask (ANDed with valid)
    logic             exr;
    logic             cv;
    logic [IDX_W-1:0] ci;
    logic             fl;
    logic             ev;    // expected outputs observed during this row
    logic [IDX_W-1:0] ei;
    logic [CNT_W-1:0] ec;
    int               push;  // index selected at this row's edge, -1 none
  } vec_t;

  vec_t vecs [NVEC];
  int   sb_q [$];
  int   n_cmp;
  int   n_err;
  int   n_xfer;

  function automatic vec_t mkv(input int v, input int r2, input int exr, input int cv,
                               input int ci, input int fl, input int ev, input int ei,
                               input int ec, input int push);
    vec_t t;
    t.v = 8'(v); t.r2 = 8'(r2); t.exr = 1'(exr); t.cv = 1'(cv); t.ci = IDX_W'(ci);
    t.fl = 1'(fl); t.ev = 1'(ev); t.ei = IDX_W'(ei); t.ec = CNT_W'(ec); t.push = push;
    return t;
  endfunction

  function automatic rs_d mk_entry(input int idx, input logic v, input logic r2);
    rs_d e;
    e.valid   = v;
    e.r1      = v;
    e.r2      = r2;
    e.op      = 4'(idx);
    e.v1      = 32'hA5A5_0000 ^ 32'(idx * 17);
    e.v2      = 32'h0000_1000 + 32'(idx * 3);
    e.rob_tag = 4'(15 - idx);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_station(input logic [7:0] v, input logic [7:0] r2);
    for (int i = 0; i < SIZE; i++) bus.rs_data[i] = mk_entry(i, v[i], v[i] & r2[i]);
  endtask

  task automatic set_ctl(input logic exr, input logic cv, input logic [IDX_W-1:0] ci,
                         input logic fl);
    bus.ex_ready   = exr;
    bus.cmpl_valid = cv;
    bus.cmpl_idx   = ci;
    bus.flush      = fl;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [IDX_W-1:0] ei,
                         input logic [CNT_W-1:0] ec);
    chk({tag, "_valid"}, 128'(bus.ex_valid), 128'(ev));
    chk({tag, "_idx"},   128'(bus.ex_idx),   128'(ei));
    chk({tag, "_cnt"},   128'(bus.inflight_cnt), 128'(ec));
    if (ev) chk({tag, "_entry"}, 128'(bus.ex_entry), 128'(mk_entry(int'(ei), 1'b1, 1'b1)));
  endtask

  // Check free and any transfer for the current inputs, then advance a cycle.
  task automatic tick();
    logic [SIZE-1:0] ef;
    int e;
    #1;
    ef = '0;
    if (bus.cmpl_valid && !bus.flush) ef[bus.cmpl_idx] = 1'b1;
    chk("free", 128'(bus.free), 128'(ef));
    if (bus.ex_valid && bus.ex_ready) begin
      n_xfer++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL xfer: got issue of idx %0d expected none", bus.ex_idx);
      end else begin
        e = sb_q.pop_front();
        chk("xfer_idx",   128'(bus.ex_idx),   128'(e));
        chk("xfer_entry", 128'(bus.ex_entry), 128'(mk_entry(e, 1'b1, 1'b1)));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int last_idx;
    n_cmp  = 0;
    n_err  = 0;
    n_xfer = 0;

    //           v     r2    exr cv ci fl  ev ei ec push
    vecs[0]  = mkv('h24, 'hFF, 1, 0, 0, 0, 0, 0, 0, 2);
    vecs[1]  = mkv('h24, 'hFF, 1, 0, 0, 0, 1, 2, 1, 5);
    vecs[2]  = mkv('h24, 'hFF, 1, 0, 0, 0, 1, 5, 2, -1);
    vecs[3]  = mkv('h24, 'hFF, 1, 1, 2, 0, 0, 5, 2, -1);
    vecs[4]  = mkv('h20, 'hFF, 1, 0, 0, 0, 0, 5, 1, -1);
    vecs[5]  = mkv('h20, 'hFF, 1, 1, 5, 0, 0, 5, 1, -1);
    vecs[6]  = mkv('h08, 'hFF, 0, 0, 0, 0, 0, 5, 0, 3);
    vecs[7]  = mkv('h0B, 'hFF, 0, 0, 0, 0, 1, 3, 1, -1);
    vecs[8]  = mkv('h0B, 'hFF, 0, 0, 0, 0, 1, 3, 1, -1);
    vecs[9]  = mkv('h0B, 'hFF, 0, 0, 0, 0, 1, 3, 1, -1);
    vecs[10] = mkv('h0B, 'hFF, 1, 0, 0, 0, 1, 3, 1, 0);
    vecs[11] = mkv('h0B, 'hFF, 1, 0, 0, 0, 1, 0, 2, 1);
    vecs[12] = mkv('h0B, 'hFF, 1, 0, 0, 0, 1, 1, 3, -1);
    vecs[13] = mkv('h1B, 'hFF, 1, 0, 0, 0, 0, 1, 3, -1);
    vecs[14] = mkv('h1B, 'hFF, 0, 0, 0, 0, 1, 4, 4, -1);
    vecs[15] = mkv('h1B, 'hFF, 0, 1, 0, 1, 1, 4, 4, -1);
    vecs[16] = mkv('h00, 'hFF, 1, 0, 0, 0, 0, 4, 0, -1);
    vecs[17] = mkv('h02, 'hFD, 1, 0, 0, 0, 0, 4, 0, -1);
    vecs[18] = mkv('h02, 'hFD, 1, 0, 0, 0, 0, 4, 0, -1);
    vecs[19] = mkv('h02, 'hFF, 1, 0, 0, 0, 0, 4, 0, 1);
    vecs[20] = mkv('h02, 'hFF, 1, 0, 0, 0, 1, 1, 1, -1);
    vecs[21] = mkv('h02, 'hFF, 1, 1, 1, 0, 0, 1, 1, -1);
    vecs[22] = mkv('h00, 'hFF, 1, 1, 6, 0, 0, 1, 0, -1);
    vecs[23] = mkv('h00, 'hFF, 1, 0, 0, 0, 0, 1, 0, -1);
    vecs[24] = mkv('h40, 'hFF, 1, 0, 0, 0, 0, 1, 0, 6);
    vecs[25] = mkv('hC0, 'hFF, 1, 0, 0, 0, 1, 6, 1, 7);
    vecs[26] = mkv('hC1, 'hFF, 1, 1, 6, 0, 1, 7, 2, 0);
    vecs[27] = mkv('h81, 'hFF, 1, 0, 0, 0, 1, 0, 2, -1);
    vecs[28] = mkv('h81, 'hFF, 1, 0, 0, 0, 0, 0, 2, -1);

    rst = 1'b1;
    set_station(8'h00, 8'hFF);
    set_ctl(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, '0, '0);
    chk("reset_entry", 128'(bus.ex_entry), 128'(0));
    chk("reset_free",  128'(bus.free),     128'(0));

    for (int k = 0; k < NVEC; k++) begin
      set_station(vecs[k].v, vecs[k].r2);
      set_ctl(vecs[k].exr, vecs[k].cv, vecs[k].ci, vecs[k].fl);
      if (vecs[k].push >= 0) sb_q.push_back(vecs[k].push);
      chk_out($sformatf("row%0d", k), vecs[k].ev, vecs[k].ei, vecs[k].ec);
      tick();
    end

    // Flush, then issue and retire entry 5 so the next scan starts at 6.
    set_station(8'h00, 8'hFF);
    set_ctl(1'b0, 1'b0, '0, 1'b1);
    tick();
    set_station(8'h20, 8'hFF);
    set_ctl(1'b1, 1'b0, '0, 1'b0);
    sb_q.push_back(5);
    chk_out("pre5", 1'b0, 3'd0, 4'd0);
    tick();
    chk_out("held5", 1'b1, 3'd5, 4'd1);
    tick();
    set_ctl(1'b1, 1'b1, 3'd5, 1'b0);
    chk_out("done5", 1'b0, 3'd5, 4'd1);
    tick();

    // All eight entries ready back to back.
    set_station(8'hFF, 8'hFF);
    set_ctl(1'b1, 1'b0, '0, 1'b0);
`ifdef RS_ISSUE_RR_EN
    for (int i = 0; i < SIZE; i++) sb_q.push_back((6 + i) % SIZE);
    last_idx = 5;
`else
    for (int i = 0; i < SIZE; i++) sb_q.push_back(i);
    last_idx = 7;
`endif
    chk_out("all_start", 1'b0, 3'd5, 4'd0);
    start = n_xfer;
    for (int c = 0; c < 24 && (n_xfer - start) < SIZE; c++) tick();
    if ((n_xfer - start) < SIZE) begin
      n_cmp++;
      n_err++;
      $display("FAIL all_xfer: got %0d transfers expected %0d", n_xfer - start, SIZE);
    end
    chk_out("all_issued", 1'b0, IDX_W'(last_idx), 4'd8);

    // Retire 2, re-fill it, hold it, then reset mid-operation.
    set_ctl(1'b0, 1'b1, 3'd2, 1'b0);
    tick();
    set_station(8'hFB, 8'hFF);
    set_ctl(1'b0, 1'b0, '0, 1'b0);
    chk_out("ret2", 1'b0, IDX_W'(last_idx), 4'd7);
    tick();
    set_station(8'hFF, 8'hFF);
    tick();
    chk_out("held2", 1'b1, 3'd2, 4'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_station(8'h00, 8'hFF);
    #1;
    chk_out("midreset", 1'b0, '0, '0);
    chk("midreset_entry", 128'(bus.ex_entry), 128'(0));

    chk("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
